// File: rtl/capture_pkg.sv
// Shared types and constants for the image capture controller.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        TRIGGER    = 2'd1,
        WAIT_FRAME = 2'd2,
        CAPTURE    = 2'd3
    } state_t;

    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 2**20;

endpackage

// File: rtl/capture_mem.sv
// Simple dual-port frame store: one write port, one registered read port.
// A same-address read and write returns the previously stored word.
module capture_mem #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/image_capture_ctrl.sv
// Sensor frame capture controller: triggers the sensor, stores an ROI window into RAM.
// Optional capture watchdog enabled by defining CAPTURE_TIMEOUT_EN.
module image_capture_ctrl
    import capture_pkg::*;
#(
    parameter int PIX_W       = 12,
    parameter int ROI_W       = 320,
    parameter int ROI_H       = 240,
    parameter int TRIG_CYCLES = 3840,
    localparam int ADDR_W     = $clog2(ROI_W*ROI_H)
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    input  logic [15:0]       colStart,
    input  logic [15:0]       rowStart,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        frameCount,
    output logic              sensorTrigger,
    input  logic [PIX_W-1:0]  sensorDout,
    input  logic              sensorPixclk,
    input  logic              sensorLineValid,
    input  logic              sensorFrameValid,
    input  logic [ADDR_W-1:0] readAddr,
    output logic [PIX_W-1:0]  readData,
    output state_t            stateDbg
);

    localparam int SW = PIX_W + 3;
    localparam int TW = $clog2(TRIG_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROI_W*ROI_H - 1);

    state_t state, state_next;

    logic [SW-1:0]     sync_r [SYNC_STAGES];
    logic [PIX_W-1:0]  pix_s;
    logic              pclk_s, lv_s, fv_s;
    logic              pclk_d, lv_d, fv_d;
    logic              pclk_rise, lv_fall, fv_fall;
    logic [TW-1:0]     trig_cnt;
    logic              armed;
    logic [15:0]       col, row, col0, row0;
    logic [ADDR_W-1:0] wr_addr;
    logic              in_win, pix_ev, wr_en, last_wr, wd_hit;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
        end else begin
            sync_r[0] <= {sensorDout, sensorPixclk, sensorLineValid, sensorFrameValid};
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    assign pix_s  = sync_r[SYNC_STAGES-1][SW-1:3];
    assign pclk_s = sync_r[SYNC_STAGES-1][2];
    assign lv_s   = sync_r[SYNC_STAGES-1][1];
    assign fv_s   = sync_r[SYNC_STAGES-1][0];

    assign pclk_rise = pclk_s & ~pclk_d;
    assign lv_fall   = lv_d & ~lv_s;
    assign fv_fall   = fv_d & ~fv_s;

    // Column/row count sensor coordinates; the ROI window selects which pixels land in RAM.
    assign in_win  = ({1'b0, col} >= {1'b0, col0}) && ({1'b0, col} < {1'b0, col0} + 17'(ROI_W)) &&
                     ({1'b0, row} >= {1'b0, row0}) && ({1'b0, row} < {1'b0, row0} + 17'(ROI_H));
    assign pix_ev  = (state == CAPTURE) && pclk_rise && lv_s && fv_s;
    assign wr_en   = pix_ev && in_win;
    assign last_wr = wr_en && (wr_addr == LAST_ADDR);

`ifdef CAPTURE_TIMEOUT_EN
    logic [20:0] wd_cnt;
    logic        wd_active;

    assign wd_active = (state == WAIT_FRAME) || (state == CAPTURE);
    assign wd_hit    = wd_active && (wd_cnt == 21'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)                     wd_cnt <= '0;
        else if (wd_active && !pclk_rise) wd_cnt <= wd_cnt + 21'd1;
        else                             wd_cnt <= '0;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start) state_next = TRIGGER;
            TRIGGER:    if (trig_cnt == TW'(TRIG_CYCLES - 1)) state_next = WAIT_FRAME;
            WAIT_FRAME: if (armed && fv_s) state_next = CAPTURE;
            CAPTURE: begin
                if (last_wr)      state_next = continuous ? TRIGGER : IDLE;
                else if (fv_fall) state_next = IDLE;
            end
            default:    state_next = IDLE;
        endcase
        if (wd_hit) state_next = IDLE;
        if (abort)  state_next = IDLE;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pclk_d     <= 1'b0;
            lv_d       <= 1'b0;
            fv_d       <= 1'b0;
            trig_cnt   <= '0;
            armed      <= 1'b0;
            col        <= '0;
            row        <= '0;
            col0       <= '0;
            row0       <= '0;
            wr_addr    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            frameCount <= '0;
        end else begin
            pclk_d   <= pclk_s;
            lv_d     <= lv_s;
            fv_d     <= fv_s;
            done     <= 1'b0;
            trig_cnt <= (state == TRIGGER) ? trig_cnt + 1'b1 : '0;
            // Only a low-then-high FV seen inside WAIT_FRAME starts a capture.
            armed    <= (state == WAIT_FRAME) && (armed || !fv_s);
            if (state == IDLE && start && !abort) begin
                col     <= '0;
                row     <= '0;
                wr_addr <= '0;
                error   <= 1'b0;
                col0    <= colStart;
                row0    <= rowStart;
            end
            if (state == CAPTURE && !abort) begin
                if (pix_ev) col <= col + 16'd1;
                if (lv_fall) begin
                    col <= '0;
                    row <= row + 16'd1;
                end
                if (wr_en) wr_addr <= wr_addr + 1'b1;
                if (last_wr) begin
                    done       <= 1'b1;
                    frameCount <= frameCount + 8'd1;
                    col        <= '0;
                    row        <= '0;
                    wr_addr    <= '0;
                end else if (fv_fall) begin
                    error <= 1'b1;
                end
            end
            if (wd_hit && !abort) error <= 1'b1;
        end
    end

    assign busy          = (state != IDLE);
    assign sensorTrigger = (state == TRIGGER);
    assign stateDbg      = state;

    capture_mem #(
        .DATA_W (PIX_W),
        .DEPTH  (ROI_W*ROI_H),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (pix_s),
        .raddr (readAddr),
        .rdata (readData)
    );

endmodule

// File: tb/tb_image_capture_ctrl.sv
// Directed bench for image_capture_ctrl with a 4x2 ROI and an 8-cycle trigger.
module tb_image_capture_ctrl;
    import capture_pkg::*;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0, abort = 1'b0, continuous = 1'b0;
    logic [15:0] colStart = '0, rowStart = '0;
    logic        busy, done, error, sensorTrigger;
    logic [7:0]  frameCount;
    logic [11:0] sensorDout = '0;
    logic        sensorPixclk = 1'b0, sensorLineValid = 1'b0, sensorFrameValid = 1'b0;
    logic [2:0]  readAddr = '0;
    logic [11:0] readData;
    state_t      stateDbg;

    image_capture_ctrl #(
        .PIX_W(12), .ROI_W(4), .ROI_H(2), .TRIG_CYCLES(8)
    ) dut (
        .clock(clock), .resetN(resetN), .start(start), .abort(abort), .continuous(continuous),
        .colStart(colStart), .rowStart(rowStart), .busy(busy), .done(done), .error(error),
        .frameCount(frameCount), .sensorTrigger(sensorTrigger), .sensorDout(sensorDout),
        .sensorPixclk(sensorPixclk), .sensorLineValid(sensorLineValid),
        .sensorFrameValid(sensorFrameValid), .readAddr(readAddr), .readData(readData),
        .stateDbg(stateDbg)
    );

    // Clock and global time limit
    always #5 clock = ~clock;

    initial begin
        #3ms;
        $display("FAIL global_timeout: simulation did not finish within 3 ms");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] col0;
        logic [15:0] row0;
        int          fw;
        int          fh;
        int          base;
        int          exp_v [8];
    } vec_t;

    vec_t        vecs [4];
    logic [11:0] exp_q [$];
    int          trig_w [$];
    int          trig_run = 0;
    int          done_cnt = 0;
    int          exp_fc = 0;
    int          vec_cnt = 0;
    int          miss_cnt = 0;

    // Monitors: done pulses and trigger pulse widths
    always @(negedge clock) begin
        if (done) done_cnt++;
        if (sensorTrigger) trig_run++;
        else if (trig_run != 0) begin
            trig_w.push_back(trig_run);
            trig_run = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetN = 1'b0;
        sensorPixclk = 1'b0; sensorLineValid = 1'b0; sensorFrameValid = 1'b0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        exp_fc = 0;
        @(negedge clock);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
    endtask

    task automatic wait_trig_end();
        int n = 0;
        while (sensorTrigger && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("trigger_end_in_time", int'(n < 200), 1);
    endtask

    // Sensor model: pixels change while pixclk is low and are sampled on its rise.
    // Stops after npix pixels, leaving LV and FV high.
    task automatic send_frame(input int fw, input int fh, input int base, input int npix);
        int n = 0;
        sensorFrameValid = 1'b1;
        repeat (8) @(negedge clock);
        for (int r = 0; r < fh; r++) begin
            sensorLineValid = 1'b1;
            for (int c = 0; c < fw; c++) begin
                if (n == npix) return;
                sensorDout = 12'(base + r*fw + c);
                sensorPixclk = 1'b0;
                repeat (4) @(negedge clock);
                sensorPixclk = 1'b1;
                repeat (4) @(negedge clock);
                n++;
            end
            sensorPixclk = 1'b0;
            repeat (4) @(negedge clock);
            sensorLineValid = 1'b0;
            repeat (8) @(negedge clock);
        end
        sensorFrameValid = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic read_check(input string name, input int n);
        logic [11:0] d;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            readAddr = 3'(k);
            @(negedge clock);
            d = readData;
            check(name, int'(d), int'(exp_q.pop_front()));
        end
    endtask

    task automatic run_vec(input int i);
        int d0;
        trig_w.delete();
        d0 = done_cnt;
        colStart = vecs[i].col0;
        rowStart = vecs[i].row0;
        pulse_start();
        wait_trig_end();
        colStart = 16'd5;
        rowStart = 16'd3;
        pulse_start();
        send_frame(vecs[i].fw, vecs[i].fh, vecs[i].base, vecs[i].fw * vecs[i].fh);
        repeat (4) @(negedge clock);
        exp_fc++;
        check("vec_done_pulses", done_cnt - d0, 1);
        check("vec_frame_count", int'(frameCount), exp_fc % 256);
        check("vec_busy_idle", int'(busy), 0);
        check("vec_error_clear", int'(error), 0);
        check("vec_trig_pulses", trig_w.size(), 1);
        check("vec_trig_width", (trig_w.size() > 0) ? trig_w[0] : -1, 8);
        for (int k = 0; k < 8; k++) exp_q.push_back(12'(vecs[i].exp_v[k]));
        read_check("vec_read_data", 8);
    endtask

    initial begin
        int d0;

        vecs[0] = '{col0: 16'd0, row0: 16'd0, fw: 4, fh: 2, base: 1, exp_v: '{1, 2, 3, 4, 5, 6, 7, 8}};
        vecs[1] = '{col0: 16'd2, row0: 16'd1, fw: 8, fh: 4, base: 0, exp_v: '{10, 11, 12, 13, 18, 19, 20, 21}};
        vecs[2] = '{col0: 16'd1, row0: 16'd0, fw: 6, fh: 3, base: 0, exp_v: '{1, 2, 3, 4, 7, 8, 9, 10}};
        vecs[3] = '{col0: 16'd0, row0: 16'd2, fw: 5, fh: 4, base: 1, exp_v: '{11, 12, 13, 14, 16, 17, 18, 19}};

        // Reset state
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_error", int'(error), 0);
        check("reset_trigger", int'(sensorTrigger), 0);
        check("reset_frame_count", int'(frameCount), 0);
        check("reset_state", int'(stateDbg), int'(IDLE));
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Continuous mode over three frames
        do_reset();
        trig_w.delete();
        d0 = done_cnt;
        continuous = 1'b1;
        colStart = 16'd0;
        rowStart = 16'd0;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_trig_end();
            send_frame(4, 2, 100 * (k + 1), 8);
        end
        wait_trig_end();
        continuous = 1'b0;
        pulse_abort();
        repeat (2) @(negedge clock);
        check("cont_done_pulses", done_cnt - d0, 3);
        check("cont_frame_count", int'(frameCount), 3);
        check("cont_trig_pulses", trig_w.size(), 4);
        for (int k = 0; k < trig_w.size(); k++) check("cont_trig_width", trig_w[k], 8);
        check("cont_busy_idle", int'(busy), 0);
        for (int k = 0; k < 8; k++) exp_q.push_back(12'(300 + k));
        read_check("cont_read_data", 8);
        exp_fc = 3;

        // Frame valid drops after five pixels
        d0 = done_cnt;
        pulse_start();
        wait_trig_end();
        send_frame(4, 2, 1, 5);
        sensorPixclk = 1'b0;
        repeat (4) @(negedge clock);
        sensorLineValid = 1'b0;
        repeat (8) @(negedge clock);
        sensorFrameValid = 1'b0;
        repeat (8) @(negedge clock);
        check("short_error_set", int'(error), 1);
        check("short_busy_idle", int'(busy), 0);
        check("short_no_done", done_cnt - d0, 0);
        check("short_frame_count", int'(frameCount), exp_fc);
        pulse_start();
        check("short_error_cleared", int'(error), 0);
        pulse_abort();
        check("short_abort_idle", int'(busy), 0);

        // Abort during trigger cycle 3, then abort against a simultaneous start
        repeat (2) @(negedge clock);
        trig_w.delete();
        d0 = done_cnt;
        pulse_start();
        @(negedge clock);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy_low", int'(busy), 0);
        check("abort_trigger_low", int'(sensorTrigger), 0);
        @(negedge clock);
        check("abort_trig_width", (trig_w.size() > 0) ? trig_w[0] : -1, 3);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", int'(busy), 0);
        check("abort_no_done", done_cnt - d0, 0);

        // Reset mid-capture, then a fresh capture behaves as after power-up
        d0 = done_cnt;
        pulse_start();
        wait_trig_end();
        send_frame(4, 2, 50, 2);
        resetN = 1'b0;
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_trigger", int'(sensorTrigger), 0);
        check("midreset_frame_count", int'(frameCount), 0);
        check("midreset_state", int'(stateDbg), int'(IDLE));
        sensorPixclk = 1'b0;
        sensorLineValid = 1'b0;
        sensorFrameValid = 1'b0;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        exp_fc = 0;
        repeat (4) @(negedge clock);
        check("midreset_no_done", done_cnt - d0, 0);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
